spi_command_decoder: RTL and testbench

SPI_COMMAND_DECODER -- requirements
Module: spi_command_decoder

---
 rtl/spi_command_decoder_pkg.sv | 26 ++
 rtl/spi_crc7.sv | 29 ++
 rtl/spi_command_decoder.sv | 180 ++++++++++++++++++
 tb/tb_spi_command_decoder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_command_decoder_pkg.sv
// Shared definitions for the SPI command frame decoder.
// Holds the FSM state encoding, CRC7 polynomial and the special byte values.
// Imported by the decoder top and its CRC7 helper.
package spi_command_decoder_pkg;

    // Decoder FSM states; encodings above HOLD are unreachable
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARG  = 3'd1,
        ST_CRC  = 3'd2,
        ST_HOLD = 3'd3
    } state_e;

    // x^7 + x^3 + 1 with the x^7 term implicit
    localparam logic [6:0] CRC7_POLY    = 7'h09;
    // Line-idle filler byte, never the start of a frame
    localparam logic [7:0] IDLE_BYTE    = 8'hFF;
    // Top two bits of a command (start) byte
    localparam logic [1:0] START_PREFIX = 2'b01;

    // True when the byte opens a new command frame
    function automatic logic is_start(input logic [7:0] b);
        return (b[7:6] == START_PREFIX);
    endfunction

endpackage

// File: rtl/spi_crc7.sv
// Byte-wise CRC7 update, MSB first, polynomial x^7 + x^3 + 1.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when to register the result.
module spi_crc7
    import spi_command_decoder_pkg::*;
(
    input  logic [6:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [6:0] crc_out
);

    logic [6:0] crc_work;
    logic       feedback;

    // Shift the eight data bits through the LFSR, most significant bit first
    always_comb begin
        crc_work = crc_in;
        feedback = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            feedback = crc_work[6] ^ byte_in[i];
            crc_work = {crc_work[5:0], 1'b0};
            if (feedback) begin
                crc_work = crc_work ^ CRC7_POLY;
            end
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/spi_command_decoder.sv
// Decodes SPI command frames (start byte, ARG_BYTES argument bytes, CRC byte) and holds a valid frame.
// Latency: status pulses appear one cycle after the byte strobe that caused them.
// Backpressure: a held frame blocks new frames until io_FrameAck; start bytes arriving meanwhile set io_Overrun.
module spi_command_decoder
    import spi_command_decoder_pkg::*;
#(
    parameter int ARG_BYTES = 4,
    parameter int CRC_CHECK = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             io_InputBuffer,
    input  logic                   io_BufferChange,
    input  logic                   io_FrameAck,
    output logic [5:0]             io_Command,
    output logic [8*ARG_BYTES-1:0] io_CommandArgument,
    output logic                   io_CommandReadFinished,
    output logic                   io_ArgumentReadFinished,
    output logic                   io_ReadSuccess,
    output logic                   io_CrcError,
    output logic                   io_FrameError,
    output logic                   io_Overrun,
    output logic                   io_FrameValid,
    output logic [2:0]             io____state
);

    localparam int         ARG_W    = 8 * ARG_BYTES;
    localparam logic [3:0] LAST_ARG = 4'(ARG_BYTES - 1);

    state_e             state_q, state_d;
    logic               change_prev_q;
    logic [5:0]         cmd_q, cmd_d;
    logic [ARG_W-1:0]   arg_q, arg_d;
    logic [6:0]         crc_q, crc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               cmd_fin_q, cmd_fin_d;
    logic               arg_fin_q, arg_fin_d;
    logic               success_q, success_d;
    logic               crc_err_q, crc_err_d;
    logic               frm_err_q, frm_err_d;
    logic               overrun_q, overrun_d;

    logic               strobe;
    logic               idle_rules;
    logic               crc_ok;
    logic [6:0]         crc_seed;
    logic [6:0]         crc_next;

    // A byte is consumed only on the rising edge of the buffer's change flag
    assign strobe = io_BufferChange & ~change_prev_q;

    // IDLE behaviour also applies to the cycle in which a held frame is released
    assign idle_rules = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && io_FrameAck);

    // Start byte seeds from zero; argument bytes continue the running CRC
    assign crc_seed = (state_q == ST_ARG) ? crc_q : 7'd0;

    // With checking disabled any CRC value is accepted
    assign crc_ok = (CRC_CHECK == 0) || (io_InputBuffer[7:1] == crc_q);

    spi_crc7 u_crc7 (
        .crc_in  (crc_seed),
        .byte_in (io_InputBuffer),
        .crc_out (crc_next)
    );

    // Next-state and register updates for the frame FSM
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        cmd_fin_d = 1'b0;
        arg_fin_d = 1'b0;
        success_d = 1'b0;
        crc_err_d = 1'b0;
        frm_err_d = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (idle_rules) begin
                    state_d = ST_IDLE;
                    if (strobe) begin
                        if (io_InputBuffer == IDLE_BYTE) begin
                            state_d = ST_IDLE;
                        end else if (is_start(io_InputBuffer)) begin
                            cmd_d     = io_InputBuffer[5:0];
                            arg_d     = '0;
                            cnt_d     = 4'd0;
                            crc_d     = crc_next;
                            cmd_fin_d = 1'b1;
                            state_d   = ST_ARG;
                        end else begin
                            frm_err_d = 1'b1;
                        end
                    end
                end else if (strobe && is_start(io_InputBuffer)) begin
                    // Frame still held: the new command cannot be accepted
                    overrun_d = 1'b1;
                end
            end

            ST_ARG: begin
                if (strobe) begin
                    arg_d = (arg_q << 8) | ARG_W'(io_InputBuffer);
                    crc_d = crc_next;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_ARG) begin
                        arg_fin_d = 1'b1;
                        state_d   = ST_CRC;
                    end
                end
            end

            ST_CRC: begin
                if (strobe) begin
                    if (!io_InputBuffer[0]) begin
                        frm_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (!crc_ok) begin
                        crc_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        success_d = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; the change-flag history resets high so a level already present is not a byte
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            change_prev_q <= 1'b1;
            cmd_q         <= '0;
            arg_q         <= '0;
            crc_q         <= '0;
            cnt_q         <= '0;
            cmd_fin_q     <= 1'b0;
            arg_fin_q     <= 1'b0;
            success_q     <= 1'b0;
            crc_err_q     <= 1'b0;
            frm_err_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            change_prev_q <= io_BufferChange;
            cmd_q         <= cmd_d;
            arg_q         <= arg_d;
            crc_q         <= crc_d;
            cnt_q         <= cnt_d;
            cmd_fin_q     <= cmd_fin_d;
            arg_fin_q     <= arg_fin_d;
            success_q     <= success_d;
            crc_err_q     <= crc_err_d;
            frm_err_q     <= frm_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign io_Command              = cmd_q;
    assign io_CommandArgument      = arg_q;
    assign io_CommandReadFinished  = cmd_fin_q;
    assign io_ArgumentReadFinished = arg_fin_q;
    assign io_ReadSuccess          = success_q;
    assign io_CrcError             = crc_err_q;
    assign io_FrameError           = frm_err_q;
    assign io_Overrun              = overrun_q;
    assign io_FrameValid           = (state_q == ST_HOLD);
    assign io____state             = state_q;

endmodule

// File: tb/tb_spi_command_decoder.sv
// Directed bench for spi_command_decoder: default instance plus a 2-byte, CRC-unchecked instance.
// Bytes are driven from negedge; outputs are sampled on the negedge after each strobe.
// Pulse counters run on every negedge to catch stray or repeated pulses.
module tb_spi_command_decoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  io_InputBuffer = 8'h00;
    logic        io_BufferChange = 1'b0;
    logic        io_FrameAck = 1'b0;

    logic [5:0]  cmd;
    logic [31:0] arg;
    logic        cmd_fin, arg_fin, succ, crc_err, frm_err, overrun, fvalid;
    logic [2:0]  state;

    logic [5:0]  cmd2;
    logic [15:0] arg2;
    logic        cmd_fin2, arg_fin2, succ2, crc_err2, frm_err2, overrun2, fvalid2;
    logic [2:0]  state2;

    int checks = 0;
    int errors = 0;

    int n_cmd_fin = 0, n_arg_fin = 0, n_succ = 0, n_crc = 0, n_frm = 0;

    // Values seen on the negedge right after the most recent strobe
    logic p_cmd_fin, p_arg_fin, p_succ, p_crc, p_frm;
    logic p2_succ, p2_frm;

    logic [7:0] seq [8];

    always #5 clock = ~clock;

    spi_command_decoder dut (
        .clock(clock), .reset(reset),
        .io_InputBuffer(io_InputBuffer), .io_BufferChange(io_BufferChange), .io_FrameAck(io_FrameAck),
        .io_Command(cmd), .io_CommandArgument(arg),
        .io_CommandReadFinished(cmd_fin), .io_ArgumentReadFinished(arg_fin),
        .io_ReadSuccess(succ), .io_CrcError(crc_err), .io_FrameError(frm_err),
        .io_Overrun(overrun), .io_FrameValid(fvalid), .io____state(state)
    );

    spi_command_decoder #(.ARG_BYTES(2), .CRC_CHECK(0)) dut2 (
        .clock(clock), .reset(reset),
        .io_InputBuffer(io_InputBuffer), .io_BufferChange(io_BufferChange), .io_FrameAck(io_FrameAck),
        .io_Command(cmd2), .io_CommandArgument(arg2),
        .io_CommandReadFinished(cmd_fin2), .io_ArgumentReadFinished(arg_fin2),
        .io_ReadSuccess(succ2), .io_CrcError(crc_err2), .io_FrameError(frm_err2),
        .io_Overrun(overrun2), .io_FrameValid(fvalid2), .io____state(state2)
    );

    // Count every cycle in which a pulse output of the default instance is high
    always @(negedge clock) begin
        if (cmd_fin === 1'b1) n_cmd_fin++;
        if (arg_fin === 1'b1) n_arg_fin++;
        if (succ    === 1'b1) n_succ++;
        if (crc_err === 1'b1) n_crc++;
        if (frm_err === 1'b1) n_frm++;
    end

    // Present one byte with the change flag high for 'hold' cycles, optionally acking on the strobe cycle
    task automatic send_byte(input logic [7:0] b, input int hold, input logic ack);
        @(negedge clock);
        io_InputBuffer  = b;
        io_BufferChange = 1'b1;
        io_FrameAck     = ack;
        @(negedge clock);
        io_FrameAck = 1'b0;
        p_cmd_fin = cmd_fin;
        p_arg_fin = arg_fin;
        p_succ    = succ;
        p_crc     = crc_err;
        p_frm     = frm_err;
        p2_succ   = succ2;
        p2_frm    = frm_err2;
        repeat (hold - 1) @(negedge clock);
        io_BufferChange = 1'b0;
    endtask

    task automatic send_seq(input int n, input int hold);
        for (int i = 0; i < n; i++) send_byte(seq[i], hold, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic ack_frame();
        @(negedge clock);
        io_FrameAck = 1'b1;
        @(negedge clock);
        io_FrameAck = 1'b0;
    endtask

    task automatic test_reset();
        // Change flag already high with a start byte present while reset releases
        reset = 1'b1;
        io_InputBuffer = 8'h40;
        io_BufferChange = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (fvalid !== 1'b0) begin errors++; $display("FAIL reset_fvalid: got %b want 0", fvalid); end
        checks++; if (cmd !== 6'd0 || arg !== 32'd0) begin errors++; $display("FAIL reset_cmd_arg: got %h/%h want 0/0", cmd, arg); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (n_cmd_fin !== 0) begin errors++; $display("FAIL reset_no_strobe: got %0d cmd pulses want 0", n_cmd_fin); end
        io_BufferChange = 1'b0;
    endtask

    task automatic test_cmd0();
        send_byte(8'hFF, 1, 1'b0);
        checks++; if (state !== 3'd0 || p_frm !== 1'b0) begin errors++; $display("FAIL cmd0_ff_ignored: got state %0d ferr %b want 0 0", state, p_frm); end
        send_byte(8'h40, 1, 1'b0);
        checks++; if (p_cmd_fin !== 1'b1 || state !== 3'd1) begin errors++; $display("FAIL cmd0_cmd_fin: got %b state %0d want 1 state 1", p_cmd_fin, state); end
        for (int i = 0; i < 4; i++) send_byte(8'h00, 1, 1'b0);
        checks++; if (p_arg_fin !== 1'b1 || state !== 3'd2) begin errors++; $display("FAIL cmd0_arg_fin: got %b state %0d want 1 state 2", p_arg_fin, state); end
        send_byte(8'h95, 1, 1'b0);
        checks++; if (p_succ !== 1'b1 || fvalid !== 1'b1 || state !== 3'd3) begin errors++; $display("FAIL cmd0_success: got succ %b fv %b state %0d want 1 1 3", p_succ, fvalid, state); end
        checks++; if (cmd !== 6'd0 || arg !== 32'd0) begin errors++; $display("FAIL cmd0_fields: got %h/%h want 0/0", cmd, arg); end
        repeat (4) @(negedge clock);
        checks++; if (fvalid !== 1'b1) begin errors++; $display("FAIL cmd0_hold: got %b want 1", fvalid); end
        ack_frame();
        checks++; if (fvalid !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL cmd0_ack: got fv %b state %0d want 0 0", fvalid, state); end
    endtask

    task automatic test_cmd8();
        seq = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87, 8'h00, 8'h00};
        send_seq(6, 1);
        checks++; if (p_succ !== 1'b1 || cmd !== 6'd8 || arg !== 32'h0000_01AA) begin errors++; $display("FAIL cmd8_good: got succ %b cmd %h arg %h want 1 08 000001aa", p_succ, cmd, arg); end
        ack_frame();
        seq[5] = 8'h89;
        send_seq(6, 1);
        checks++; if (p_crc !== 1'b1 || p_succ !== 1'b0) begin errors++; $display("FAIL cmd8_crc_err: got crc %b succ %b want 1 0", p_crc, p_succ); end
        checks++; if (state !== 3'd0 || fvalid !== 1'b0) begin errors++; $display("FAIL cmd8_crc_idle: got state %0d fv %b want 0 0", state, fvalid); end
        checks++; if (cmd !== 6'd8 || arg !== 32'h0000_01AA) begin errors++; $display("FAIL cmd8_keep_fields: got %h/%h want 08/000001aa", cmd, arg); end
    endtask

    task automatic test_frame_error();
        seq = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h94, 8'h00, 8'h00};
        send_seq(6, 1);
        checks++; if (p_frm !== 1'b1 || p_crc !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL ferr_stop_bit: got ferr %b crc %b state %0d want 1 0 0", p_frm, p_crc, state); end
        send_byte(8'h80, 1, 1'b0);
        checks++; if (p_frm !== 1'b1 || state !== 3'd0) begin errors++; $display("FAIL ferr_idle_byte: got ferr %b state %0d want 1 0", p_frm, state); end
    endtask

    task automatic test_overrun();
        int s0;
        do_reset();
        seq = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'h00, 8'h00};
        send_seq(6, 1);
        #1;
        s0 = n_succ;
        seq = '{8'h51, 8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00};
        send_seq(6, 1);
        #1;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        checks++; if (cmd !== 6'd0 || arg !== 32'd0 || fvalid !== 1'b1 || state !== 3'd3) begin errors++; $display("FAIL ovr_held: got cmd %h arg %h fv %b state %0d want 00 0 1 3", cmd, arg, fvalid, state); end
        checks++; if (n_succ - s0 !== 0) begin errors++; $display("FAIL ovr_no_success: got %0d pulses want 0", n_succ - s0); end
        send_byte(8'h51, 1, 1'b1);
        checks++; if (p_cmd_fin !== 1'b1 || state !== 3'd1) begin errors++; $display("FAIL ovr_ack_start: got %b state %0d want 1 state 1", p_cmd_fin, state); end
        for (int i = 1; i < 6; i++) send_byte(seq[i], 1, 1'b0);
        checks++; if (p_succ !== 1'b1 || cmd !== 6'd17 || arg !== 32'd0) begin errors++; $display("FAIL ovr_cmd17: got succ %b cmd %0d arg %h want 1 17 0", p_succ, cmd, arg); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        ack_frame();
    endtask

    task automatic test_long_strobe_and_reset();
        int c0, a0, s0, f0, e0;
        #1;
        c0 = n_cmd_fin; a0 = n_arg_fin; s0 = n_succ;
        seq = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'h00, 8'h00};
        send_seq(6, 5);
        #1;
        checks++; if (n_cmd_fin - c0 !== 1 || n_arg_fin - a0 !== 1 || n_succ - s0 !== 1) begin errors++; $display("FAIL long_strobe_counts: got %0d/%0d/%0d want 1/1/1", n_cmd_fin - c0, n_arg_fin - a0, n_succ - s0); end
        checks++; if (fvalid !== 1'b1) begin errors++; $display("FAIL long_strobe_valid: got %b want 1", fvalid); end
        ack_frame();
        send_seq(3, 1);
        #1;
        c0 = n_cmd_fin; a0 = n_arg_fin; s0 = n_succ; f0 = n_frm; e0 = n_crc;
        do_reset();
        repeat (3) @(negedge clock);
        #1;
        checks++; if (state !== 3'd0 || fvalid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL midreset_state: got state %0d fv %b ovr %b want 0 0 0", state, fvalid, overrun); end
        checks++; if (n_cmd_fin != c0 || n_arg_fin != a0 || n_succ != s0 || n_frm != f0 || n_crc != e0) begin errors++; $display("FAIL midreset_pulses: got extra %0d/%0d/%0d/%0d/%0d want none", n_cmd_fin - c0, n_arg_fin - a0, n_succ - s0, n_frm - f0, n_crc - e0); end
        send_seq(6, 1);
        checks++; if (p_succ !== 1'b1 || fvalid !== 1'b1) begin errors++; $display("FAIL midreset_recover: got succ %b fv %b want 1 1", p_succ, fvalid); end
        ack_frame();
    endtask

    task automatic test_short_nocrc();
        do_reset();
        seq = '{8'h45, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq(4, 1);
        checks++; if (p2_frm !== 1'b1 || state2 !== 3'd0) begin errors++; $display("FAIL short_stop_bit: got ferr %b state %0d want 1 0", p2_frm, state2); end
        seq[3] = 8'h01;
        send_seq(4, 1);
        checks++; if (p2_succ !== 1'b1 || cmd2 !== 6'd5 || arg2 !== 16'h1234) begin errors++; $display("FAIL short_success: got succ %b cmd %0d arg %h want 1 5 1234", p2_succ, cmd2, arg2); end
        checks++; if (fvalid2 !== 1'b1) begin errors++; $display("FAIL short_valid: got %b want 1", fvalid2); end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_frame_error();
        test_overrun();
        test_long_strobe_and_reset();
        test_short_nocrc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
